// File: rtl/dm_lsu.sv
// Load/store unit between the MEM stage and a word-addressed data memory.
// Converts byte/half/word requests to word accesses, with read-modify-write for sub-word stores.
module dm_lsu #(
    parameter int DEPTH = 401
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic        DMWE,
    output logic [31:0] DMA,
    output logic [31:0] DMWD,
    input  logic [31:0] DMRD
);

    typedef enum logic [2:0] {IDLE, LOAD, WRITE, RMW_RD, RMW_WR} state_t;

    state_t      state, state_nx;
    logic        accept;
    logic        req_err;
    logic        we_p0;
    logic [1:0]  size_p0;
    logic        sgn_p0;
    logic [31:0] addr_p0;
    logic [31:0] wdata_p0;
    logic [31:0] buf_p0;

    function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] size,
                                                 input logic sgn, input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (size)
            2'b00:   return sgn ? {{24{b[7]}}, b} : {24'b0, b};
            2'b01:   return sgn ? {{16{h[15]}}, h} : {16'b0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [1:0] size, input logic [1:0] off);
        logic [31:0] r;
        r = old;
        case (size)
            2'b00: r[{off, 3'b000} +: 8] = wd[7:0];
            2'b01: begin
                if (off[1]) r[31:16] = wd[15:0];
                else        r[15:0]  = wd[15:0];
            end
            default: r = wd;
        endcase
        return r;
    endfunction

    // Errors are decided from the live request so no memory cycle is ever issued for them.
    always_comb begin
        req_err = 1'b0;
        if (req_size == 2'b11)                            req_err = 1'b1;
        if (req_size == 2'b01 && req_addr[0])             req_err = 1'b1;
        if (req_size == 2'b10 && req_addr[1:0] != 2'b00)  req_err = 1'b1;
        if ({2'b00, req_addr[31:2]} >= 32'(DEPTH))        req_err = 1'b1;
    end

    assign accept = (state == IDLE) && req_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        DMWE      = 1'b0;
        DMA       = 32'b0;
        DMWD      = 32'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid && !req_err) begin
                    if (!req_we)                 state_nx = LOAD;
                    else if (req_size == 2'b10)  state_nx = WRITE;
                    else                         state_nx = RMW_RD;
                end
            end
            LOAD: begin
                DMA      = {2'b00, addr_p0[31:2]};
                state_nx = IDLE;
            end
            WRITE: begin
                DMWE     = 1'b1;
                DMA      = {2'b00, addr_p0[31:2]};
                DMWD     = wdata_p0;
                state_nx = IDLE;
            end
            RMW_RD: begin
                DMA      = {2'b00, addr_p0[31:2]};
                state_nx = RMW_WR;
            end
            RMW_WR: begin
                DMWE     = 1'b1;
                DMA      = {2'b00, addr_p0[31:2]};
                DMWD     = buf_p0;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Request latch, merge buffer and single-cycle response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_p0     <= 1'b0;
            size_p0   <= 2'b00;
            sgn_p0    <= 1'b0;
            addr_p0   <= 32'b0;
            wdata_p0  <= 32'b0;
            buf_p0    <= 32'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'b0;
            if (accept) begin
                we_p0    <= req_we;
                size_p0  <= req_size;
                sgn_p0   <= req_signed;
                addr_p0  <= req_addr;
                wdata_p0 <= req_wdata;
                if (req_err) begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b1;
                end
            end
            case (state)
                LOAD: begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= load_extract(DMRD, size_p0, sgn_p0, addr_p0[1:0]);
                end
                WRITE, RMW_WR: rsp_valid <= 1'b1;
                RMW_RD: buf_p0 <= store_merge(DMRD, wdata_p0, size_p0, addr_p0[1:0]);
                default: ;
            endcase
        end
    end

    logic unused_we;
    assign unused_we = we_p0;

endmodule

// File: tb/tb_dm_lsu.sv
// Self-checking bench for dm_lsu: memory model, transaction-level reference and scoreboard.
module tb_dm_lsu;

    localparam int DEPTH = 401;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'b0;
    logic [31:0] req_wdata = 32'b0;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        DMWE;
    logic [31:0] DMA;
    logic [31:0] DMWD;
    logic [31:0] DMRD;

    dm_lsu #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
        .rsp_rdata(rsp_rdata), .DMWE(DMWE), .DMA(DMA), .DMWD(DMWD), .DMRD(DMRD)
    );

    always #5 clk = ~clk;

    // Data memory seen by the DUT, plus a back-door preload port.
    logic [31:0] mem [0:DEPTH-1];
    logic        pre_we = 1'b0;
    logic [8:0]  pre_idx = 9'd0;
    logic [31:0] pre_data = 32'b0;

    always @(posedge clk) begin
        if (pre_we) mem[pre_idx] <= pre_data;
        else if (DMWE && DMA < 32'(DEPTH)) mem[DMA[8:0]] <= DMWD;
    end
    assign DMRD = (DMA < 32'(DEPTH)) ? mem[DMA[8:0]] : 32'hDEADBEEF;

    logic [31:0] ref_mem [0:DEPTH-1];

    typedef struct {
        bit          err;
        logic [31:0] rdata;
        int          lat;
        bit          wr;
        logic [31:0] widx;
        logic [31:0] wword;
        int          acc;
    } exp_t;

    exp_t        q[$];
    int          ntests = 0;
    int          nfail = 0;
    int          cyc = 0;
    bit          wr_seen = 0;
    logic [31:0] last_rdata = 32'b0;
    logic        last_err = 1'b0;
    int          last_lat = 0;
    logic [31:0] last_widx = 32'b0;
    logic [31:0] last_wword = 32'b0;
    bit          acc_in_rsp = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        ntests++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [1:0] sz);
        if (sz == 2'b00) return 32'h0000_00FF;
        if (sz == 2'b01) return 32'h0000_FFFF;
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] sz,
                                           input bit sg, input logic [1:0] off);
        logic [31:0] mask;
        logic [31:0] v;
        int          nb;
        mask = lane_mask(sz);
        nb = (sz == 2'b00) ? 8 : (sz == 2'b01) ? 16 : 32;
        v = (w >> (8 * off)) & mask;
        if (nb < 32 && sg && v[nb-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [31:0] m_merge(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [1:0] sz, input logic [1:0] off);
        logic [31:0] mask;
        mask = lane_mask(sz);
        return (old & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
    endfunction

    // Scoreboard: checks memory write pulses and every response against the queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (DMWE) begin
                if (q.size() == 0 || !q[0].wr || wr_seen) begin
                    chk("dmwe_unexpected", {31'b0, DMWE}, 32'd0);
                end else begin
                    chk("dmwe_addr", DMA, q[0].widx);
                    chk("dmwe_data", DMWD, q[0].wword);
                    last_widx = DMA;
                    last_wword = DMWD;
                    wr_seen = 1;
                end
            end
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    chk("rsp_unexpected", {31'b0, rsp_valid}, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    last_rdata = rsp_rdata;
                    last_err = rsp_err;
                    last_lat = cyc - e.acc + 1;
                    chk("rsp_latency", 32'(last_lat), 32'(e.lat));
                    chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    if (e.wr) chk("dmwe_missing", {31'b0, wr_seen}, 32'd1);
                    wr_seen = 0;
                end
            end else begin
                chk("idle_rsp_zero", {rsp_err, rsp_rdata[30:0]} | {31'b0, rsp_rdata[31]}, 32'd0);
            end
        end
    end

    task automatic preload(input int idx, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1;
        pre_idx = 9'(idx);
        pre_data = d;
        ref_mem[idx] = d;
        @(posedge clk);
        #1 pre_we = 1'b0;
    endtask

    task automatic send(input bit we, input logic [1:0] sz, input bit sg,
                        input logic [31:0] a, input logic [31:0] wd);
        exp_t        e;
        int          n;
        logic [31:0] idx;
        @(negedge clk);
        req_we = we;
        req_size = sz;
        req_signed = sg;
        req_addr = a;
        req_wdata = wd;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("accept_timeout", {31'b0, req_ready}, 32'd1);
            req_valid = 1'b0;
            return;
        end
        acc_in_rsp = rsp_valid;
        idx = a >> 2;
        e.err = (sz == 2'b11) || (sz == 2'b01 && a % 2 != 0) || (sz == 2'b10 && a % 4 != 0)
                || (idx >= 32'(DEPTH));
        e.rdata = 32'b0;
        e.wr = 0;
        e.widx = idx;
        e.wword = 32'b0;
        if (e.err) begin
            e.lat = 1;
        end else if (!we) begin
            e.lat = 2;
            e.rdata = m_load(ref_mem[idx], sz, sg, a[1:0]);
        end else begin
            e.lat = (sz == 2'b10) ? 2 : 3;
            e.wr = 1;
            e.wword = m_merge(ref_mem[idx], wd, sz, a[1:0]);
            ref_mem[idx] = e.wword;
        end
        @(posedge clk);
        #1;
        e.acc = cyc;
        q.push_back(e);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (q.size() != 0) begin
            chk("rsp_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
    endtask

    initial begin
        #2;
        chk("reset_ready", {31'b0, req_ready}, 32'd1);
        chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("reset_dmwe", {31'b0, DMWE}, 32'd0);
        chk("reset_dma", DMA, 32'd0);
        chk("reset_dmwd", DMWD, 32'd0);
        chk("reset_rdata", rsp_rdata, 32'd0);
        for (int i = 0; i < DEPTH; i++) preload(i, $urandom);
        @(negedge clk) rst_n = 1'b1;

        preload(1, 32'd31);
        preload(2, 32'hFFFF_FFFB);
        preload(4, 32'h0000_00FA);

        send(0, 2'b10, 0, 32'h4, 32'h0);
        wait_idle();
        chk("ld_word_rdata", last_rdata, 32'h0000_001F);
        chk("ld_word_err", {31'b0, last_err}, 32'd0);
        chk("ld_word_lat", 32'(last_lat), 32'd2);

        send(0, 2'b00, 1, 32'h8, 32'h0);
        wait_idle();
        chk("ld_byte_signed", last_rdata, 32'hFFFF_FFFB);
        send(0, 2'b00, 0, 32'h8, 32'h0);
        wait_idle();
        chk("ld_byte_unsigned", last_rdata, 32'h0000_00FB);

        send(1, 2'b01, 0, 32'h12, 32'h0000_ABCD);
        wait_idle();
        chk("st_half_lat", 32'(last_lat), 32'd3);
        chk("st_half_dma", last_widx, 32'd4);
        chk("st_half_dmwd", last_wword, 32'hABCD_00FA);
        chk("st_half_mem", mem[4], 32'hABCD_00FA);

        send(1, 2'b10, 0, 32'h6, 32'h1);
        wait_idle();
        chk("err_misaligned", {31'b0, last_err}, 32'd1);
        chk("err_lat", 32'(last_lat), 32'd1);
        send(0, 2'b10, 0, 32'(DEPTH * 4), 32'h0);
        wait_idle();
        chk("err_range", {31'b0, last_err}, 32'd1);
        send(0, 2'b11, 0, 32'h0, 32'h0);
        wait_idle();
        chk("err_size", {31'b0, last_err}, 32'd1);

        send(1, 2'b10, 0, 32'h0, 32'h1234_5678);
        send(0, 2'b10, 0, 32'h0, 32'h0);
        chk("b2b_accept_in_rsp", {31'b0, acc_in_rsp}, 32'd1);
        wait_idle();
        chk("b2b_rdata", last_rdata, 32'h1234_5678);

        // Reset while the read-modify-write is in its write cycle.
        preload(7, 32'h1122_3344);
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'd29; req_wdata = 32'h55; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #2;
        chk("rmw_wr_dmwe", {31'b0, DMWE}, 32'd1);
        chk("rmw_wr_dma", DMA, 32'd7);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_dmwe", {31'b0, DMWE}, 32'd0);
        chk("rst_dma", DMA, 32'd0);
        chk("rst_dmwd", DMWD, 32'd0);
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 chk("rst_mem_kept", mem[7], 32'h1122_3344);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] idx;
            logic [1:0]  off;
            int          r;
            r = $urandom_range(0, 19);
            if (r == 0)      idx = 32'h3FFF_FFFF;
            else if (r < 3)  idx = 32'(DEPTH) + $urandom_range(0, 7);
            else if (r < 10) idx = $urandom_range(0, 7);
            else             idx = $urandom_range(0, DEPTH - 1);
            off = 2'($urandom_range(0, 3));
            send(1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2)),
                 1'($urandom_range(0, 1)), {idx[29:0], off}, $urandom);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
        end
        wait_idle();
        for (int i = 0; i < 8; i++) chk("final_mem", mem[i], ref_mem[i]);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/dm_lsu.md
# dm_lsu

Load/store unit sitting between the MEM pipeline stage and the word-addressed data memory; it is the initiator on the data-memory interface (DMWE/DMA/DMWD/DMRD). It accepts byte-addressed load/store requests of byte, halfword or word size, converts them to word accesses, and performs read-modify-write for sub-word stores. It returns sign- or zero-extended load data and flags misaligned or out-of-range accesses without touching memory.

## Interface
Parameters:
- DEPTH, 401, number of 32-bit words in the data memory; valid word indices 0..DEPTH-1
- Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_signed  in  1  loads only: 1 sign-extend, 0 zero-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- rsp_valid  out  1  one-cycle completion pulse
- rsp_err  out  1  valid with rsp_valid; 1 = misaligned/illegal/out-of-range
- rsp_rdata  out  32  load result; 0 for stores and errors
- DMWE  out  1  memory write enable
- DMA  out  32  memory word index (req_addr >> 2)
- DMWD  out  32  memory write data
- DMRD  in  32  memory read data, combinational from DMA while DMWE=0

## Operation
- States: IDLE, LOAD, WRITE, RMW_RD, RMW_WR.
- IDLE: req_ready=1; DMWE=0, DMA=0, DMWD=0. Accept on req_valid at rising edge; latch we/size/signed/addr/wdata.
- Error check at accept: size=11; half with addr[0]=1; word with addr[1:0]!=0; addr>>2 >= DEPTH. Error -> stay IDLE, next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0; no memory cycle.
- Load -> LOAD: DMA=idx, DMWE=0; DMRD sampled at next edge; -> IDLE with rsp_valid=1.
- Word store -> WRITE: DMWE=1, DMA=idx, DMWD=wdata; -> IDLE with rsp_valid=1.
- Byte/half store -> RMW_RD: DMWE=0, DMA=idx, DMRD captured into merge buffer; -> RMW_WR: DMWE=1, DMWD = buffer with target lane(s) replaced; -> IDLE with rsp_valid=1.
- Lanes little-endian: byte k = bits [8k+7:8k], k=addr[1:0]; half at addr[1]=0 -> [15:0], addr[1]=1 -> [31:16].
- Load extraction: selected lane moved to LSBs; upper bits = lane MSB if req_signed else 0. Word loads ignore req_signed.
- rsp_rdata/rsp_err registered, valid only while rsp_valid=1, otherwise 0.

## Timing
- Reset (async, immediate): state IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, DMWE=0, DMA=0, DMWD=0, buffers cleared.
- Latency accept edge -> rsp_valid cycle: error 1 cycle, load 2, word store 2, sub-word store 3.
- rsp_valid is the cycle the unit is back in IDLE; a new request may be accepted in that same cycle (back-to-back, no bubble).
- DMWE high for exactly one cycle per store, never for loads or errors.
- DMA held stable across RMW_RD and RMW_WR.
- Reset asserted during WRITE/RMW_WR drops DMWE immediately; the write is abandoned, no rsp_valid.
- req_valid while not IDLE is ignored (req_ready=0); requester must hold.

## Test plan
- Load word addr 0x4 with DM[1]=31 -> rsp_valid 2 cycles after accept, rsp_rdata=0x0000001F, rsp_err=0, DMWE never high.
- Load byte signed addr 0x8 with DM[2]=0xFFFFFFFB -> rsp_rdata=0xFFFFFFFB; same unsigned -> 0x000000FB.
- Store half 0xABCD to addr 0x12 with DM[4]=0x000000FA -> one DMWE pulse at DMA=4, DMWD=0xABCD00FA, rsp_valid 3 cycles after accept.
- Word store to addr 0x6 -> rsp_err=1 next cycle, no DMWE; addr 401*4 -> rsp_err=1; size=11 -> rsp_err=1.
- Back-to-back: store word 0x12345678 to 0x0 then load word 0x0 accepted in the rsp cycle -> load returns 0x12345678.
- Assert rst_n=0 during RMW_WR -> DMWE falls immediately, memory word unchanged, all outputs at reset values, no rsp_valid.
